ltc2333_read_impl: RTL

Receive side of the LTC2333 serial link: deserializes the two SDO lanes (one per ADC) while the write block drives CNV/SCKI/SDI, checks each 24-bit result word against the active-channel sequence, buffers per lane and emits words on an AXI-stream-style master port toward the DMA/IPIF readout. Sits in the same clk domain as the write block, fed by its cnv and clock-enable strobes.

---
 rtl/ltc2333_pkg.sv | 87 ++++++++
 rtl/ltc2333_read_impl_if.sv | 15 +
 rtl/ltc2333_lane_fifo.sv | 50 +++++
 rtl/ltc2333_read_impl.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/ltc2333_pkg.sv
// Shared LTC2333 data-format definitions: word geometry, raw-word and m_tdata
// field offsets, receive FSM states, and channel-sequence helper functions.
// Used by the read block, its lane FIFO, its output interface and any write-side logic.
package ltc2333_pkg;

  localparam int WORD_BITS = 24;
  localparam int NCHAN     = 8;
  localparam int TDATA_W   = 32;
  localparam int IDX_W     = 4;

  // raw = {result[17:0], chan_id[2:0], softspan[2:0]}
  localparam int RAW_SOFTSPAN_LSB = 0;
  localparam int RAW_SOFTSPAN_W   = 3;
  localparam int RAW_CHAN_LSB     = 3;
  localparam int RAW_CHAN_W       = 3;
  localparam int RAW_RESULT_LSB   = 6;
  localparam int RAW_RESULT_W     = 18;

  // m_tdata = {lane[31], word_idx[30:27], 3'b0, raw[23:0]}
  localparam int TD_RAW_LSB  = 0;
  localparam int TD_IDX_LSB  = 27;
  localparam int TD_LANE_BIT = 31;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_SHIFT = 2'd2
  } state_t;

  typedef logic [WORD_BITS-1:0] raw_t;

  typedef struct packed {
    logic [IDX_W-1:0] idx;
    raw_t             raw;
  } lane_word_t;

  // An all-zero mask means "every channel".
  function automatic logic [NCHAN-1:0] eff_mask(input logic [NCHAN-1:0] m);
    return (m == '0) ? '1 : m;
  endfunction

  function automatic logic [IDX_W-1:0] popcount8(input logic [NCHAN-1:0] m);
    logic [IDX_W-1:0] cnt;
    cnt = '0;
    for (int k = 0; k < NCHAN; k++) cnt = cnt + {{(IDX_W-1){1'b0}}, m[k]};
    return cnt;
  endfunction

  // Next set bit strictly after cur, wrapping mod 8. Searching from 7 yields
  // the lowest set bit, which is where a frame's sequence starts.
  function automatic logic [2:0] next_chan(input logic [NCHAN-1:0] m, input logic [2:0] cur);
    logic [2:0] nxt;
    logic       found;
    nxt   = cur;
    found = 1'b0;
    for (int k = 1; k <= NCHAN; k++) begin
      if (!found && m[cur + 3'(k)]) begin
        nxt   = cur + 3'(k);
        found = 1'b1;
      end
    end
    return nxt;
  endfunction

  function automatic raw_t mk_raw(input logic [RAW_RESULT_W-1:0] result,
                                  input logic [RAW_CHAN_W-1:0] chan,
                                  input logic [RAW_SOFTSPAN_W-1:0] softspan);
    raw_t r;
    r = '0;
    r[RAW_RESULT_LSB +: RAW_RESULT_W]     = result;
    r[RAW_CHAN_LSB +: RAW_CHAN_W]         = chan;
    r[RAW_SOFTSPAN_LSB +: RAW_SOFTSPAN_W] = softspan;
    return r;
  endfunction

  function automatic logic [TDATA_W-1:0] pack_tdata(input logic lane,
                                                    input logic [IDX_W-1:0] idx,
                                                    input raw_t raw);
    logic [TDATA_W-1:0] td;
    td = '0;
    td[TD_LANE_BIT]             = lane;
    td[TD_IDX_LSB +: IDX_W]     = idx;
    td[TD_RAW_LSB +: WORD_BITS] = raw;
    return td;
  endfunction

endpackage

// File: rtl/ltc2333_read_impl_if.sv
// AXI-stream-style word port between the LTC2333 read block and the DMA/IPIF readout.
// Signals: m_tdata (32b word), m_tvalid, m_tlast from the source; m_tready from the sink.
// master modport = word source (read block), slave modport = consumer.
interface ltc2333_read_impl_if;
  import ltc2333_pkg::*;

  logic [TDATA_W-1:0] m_tdata;
  logic               m_tvalid;
  logic               m_tready;
  logic               m_tlast;

  modport master (output m_tdata, output m_tvalid, output m_tlast, input m_tready);
  modport slave  (input m_tdata, input m_tvalid, input m_tlast, output m_tready);

endinterface

// File: rtl/ltc2333_lane_fifo.sv
// Per-lane synchronous FIFO of {word_idx, raw} entries, show-ahead read port.
// Ports: wr_en/wr_data (write ignored when full), rd_en/rd_data (pop ignored when empty), full, empty.
// A written word becomes visible (empty drops) one cycle after the write edge; DEPTH must be a power of two >= 2.
module ltc2333_lane_fifo
  import ltc2333_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       local_aresetn,
  input  logic       wr_en,
  input  lane_word_t wr_data,
  input  logic       rd_en,
  output lane_word_t rd_data,
  output logic       full,
  output logic       empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = {1'b1, {AW{1'b0}}};

  lane_word_t  mem [DEPTH];
  logic [AW:0] wr_ptr;
  logic [AW:0] wr_ptr_vis;
  logic [AW:0] rd_ptr;

  // full tracks the real write pointer so a drop decision is exact;
  // empty tracks a one-cycle-late copy, giving the extra cycle of
  // write-to-valid latency seen at the output.
  assign full    = (wr_ptr - rd_ptr) == FULL_CNT;
  assign empty   = (wr_ptr_vis == rd_ptr);
  assign rd_data = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge local_aresetn) begin
    if (!local_aresetn) begin
      wr_ptr     <= '0;
      wr_ptr_vis <= '0;
      rd_ptr     <= '0;
    end else begin
      wr_ptr_vis <= wr_ptr;
      if (wr_en && !full) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en && !empty) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en && !full) mem[wr_ptr[AW-1:0]] <= wr_data;
  end

endmodule

// File: rtl/ltc2333_read_impl.sv
// LTC2333 receive side: deserializes both SDO lanes, checks chan_id sequence, buffers per lane,
// and emits words alternately lane 0 / lane 1 on an AXI-stream master.
// Ports: clk, local_aresetn, cnv, sck_en, sdo[NLANE], active_channels, m_axis (master), overflow,
// chan_err, frame_err, clear_err. Sample SAMPLE_DELAY cycles after sck_en; words valid 2 cycles after
// the 24th sample; a full lane FIFO drops that lane's word; output holds while m_tready=0.
module ltc2333_read_impl
  import ltc2333_pkg::*;
#(
  parameter int SAMPLE_DELAY = 2,
  parameter int FIFO_DEPTH   = 4,
  parameter int NLANE        = 2
) (
  input  logic                clk,
  input  logic                local_aresetn,
  input  logic                cnv,
  input  logic                sck_en,
  input  logic [NLANE-1:0]    sdo,
  input  logic [NCHAN-1:0]    active_channels,
  ltc2333_read_impl_if.master m_axis,
  output logic                overflow,
  output logic                chan_err,
  output logic                frame_err,
  input  logic                clear_err
);

  // ---------------------------------------------------------------- strobes
  logic sck_en_d;

  generate
    if (SAMPLE_DELAY == 0) begin : g_nodly
      assign sck_en_d = sck_en;
    end else begin : g_dly
      // Matches the SCKI -> ADC -> SDO round trip so each bit is sampled
      // in the cycle its clock pulse produced it.
      logic [SAMPLE_DELAY-1:0] dly;
      always_ff @(posedge clk or negedge local_aresetn) begin
        if (!local_aresetn) dly <= '0;
        else                dly <= (dly << 1) | SAMPLE_DELAY'(sck_en);
      end
      assign sck_en_d = dly[SAMPLE_DELAY-1];
    end
  endgenerate

  logic cnv_q;
  logic cnv_rise;

  always_ff @(posedge clk or negedge local_aresetn) begin
    if (!local_aresetn) cnv_q <= 1'b0;
    else                cnv_q <= cnv;
  end

  assign cnv_rise = cnv && !cnv_q;

  logic [NCHAN-1:0] mask_eff;
  logic [IDX_W-1:0] n_chan;

  assign mask_eff = eff_mask(active_channels);
  assign n_chan   = popcount8(mask_eff);

  // ---------------------------------------------------------------- FSM
  state_t           state;
  state_t           state_nxt;
  logic             start_frame;
  logic             sample;
  logic             word_done;
  logic [4:0]       bit_cnt;
  logic [IDX_W-1:0] word_idx;
  logic [2:0]       expected_ch;

  always_ff @(posedge clk or negedge local_aresetn) begin
    if (!local_aresetn) state <= ST_IDLE;
    else                state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    start_frame = 1'b0;
    sample      = 1'b0;
    word_done   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (cnv_rise) begin
          state_nxt   = ST_ARMED;
          start_frame = 1'b1;
        end
      end
      ST_ARMED, ST_SHIFT: begin
        // A new conversion always wins over a pending bit: the partial
        // frame is abandoned and counting restarts from scratch.
        if (cnv_rise) begin
          state_nxt   = ST_ARMED;
          start_frame = 1'b1;
        end else if (sck_en_d) begin
          sample    = 1'b1;
          state_nxt = ST_SHIFT;
          if (bit_cnt == 5'd23) begin
            word_done = 1'b1;
            if (word_idx == n_chan - 1'b1) state_nxt = ST_IDLE;
          end
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // ---------------------------------------------------------------- deserializer
  raw_t             sr [NLANE];
  logic             push_pend;
  logic [IDX_W-1:0] pend_idx;
  logic [2:0]       pend_exp;

  // Completed words are pushed on the edge after their last sample; the
  // index and expected channel travel with them because the counters have
  // already moved on to the next word by then.
  always_ff @(posedge clk or negedge local_aresetn) begin
    if (!local_aresetn) begin
      bit_cnt     <= '0;
      word_idx    <= '0;
      expected_ch <= '0;
      push_pend   <= 1'b0;
      pend_idx    <= '0;
      pend_exp    <= '0;
      for (int i = 0; i < NLANE; i++) sr[i] <= '0;
    end else begin
      push_pend <= word_done;
      if (start_frame) begin
        bit_cnt     <= '0;
        word_idx    <= '0;
        expected_ch <= next_chan(mask_eff, 3'd7);
        for (int i = 0; i < NLANE; i++) sr[i] <= '0;
      end else if (sample) begin
        for (int i = 0; i < NLANE; i++) sr[i] <= {sr[i][WORD_BITS-2:0], sdo[i]};
        if (word_done) begin
          bit_cnt     <= '0;
          pend_idx    <= word_idx;
          pend_exp    <= expected_ch;
          word_idx    <= word_idx + 1'b1;
          expected_ch <= next_chan(mask_eff, expected_ch);
        end else begin
          bit_cnt <= bit_cnt + 1'b1;
        end
      end
    end
  end

  // ---------------------------------------------------------------- lane FIFOs
  lane_word_t       head [NLANE];
  logic [NLANE-1:0] fifo_full;
  logic [NLANE-1:0] fifo_empty;
  logic             rd_lane;
  logic             tvalid;
  logic             xfer;

  assign tvalid = !fifo_empty[rd_lane];
  assign xfer   = tvalid && m_axis.m_tready;

  generate
    for (genvar i = 0; i < NLANE; i++) begin : g_lane
      ltc2333_lane_fifo #(
        .DEPTH (FIFO_DEPTH)
      ) u_fifo (
        .clk           (clk),
        .local_aresetn (local_aresetn),
        .wr_en         (push_pend),
        .wr_data       ({pend_idx, sr[i]}),
        .rd_en         (xfer && (rd_lane == 1'(i))),
        .rd_data       (head[i]),
        .full          (fifo_full[i]),
        .empty         (fifo_empty[i])
      );
    end
  endgenerate

  // ---------------------------------------------------------------- output
  lane_word_t head_sel;

  assign head_sel        = head[rd_lane];
  // Output is gated with valid so an idle or freshly reset port reads 0.
  assign m_axis.m_tvalid = tvalid;
  assign m_axis.m_tdata  = tvalid ? pack_tdata(rd_lane, head_sel.idx, head_sel.raw) : '0;
  assign m_axis.m_tlast  = tvalid && rd_lane && (head_sel.idx == n_chan - 1'b1);

  always_ff @(posedge clk or negedge local_aresetn) begin
    if (!local_aresetn) rd_lane <= 1'b0;
    else if (xfer)      rd_lane <= ~rd_lane;
  end

  // ---------------------------------------------------------------- sticky errors
  logic ovf_evt;
  logic chan_evt;
  logic frame_evt;

  always_comb begin
    ovf_evt  = 1'b0;
    chan_evt = 1'b0;
    for (int i = 0; i < NLANE; i++) begin
      if (push_pend && fifo_full[i]) ovf_evt = 1'b1;
      if (push_pend && (sr[i][RAW_CHAN_LSB +: RAW_CHAN_W] != pend_exp)) chan_evt = 1'b1;
    end
  end

  assign frame_evt = cnv_rise && (state != ST_IDLE);

  // An event in the same cycle as clear_err keeps its flag set.
  always_ff @(posedge clk or negedge local_aresetn) begin
    if (!local_aresetn) begin
      overflow  <= 1'b0;
      chan_err  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      overflow  <= (overflow  && !clear_err) || ovf_evt;
      chan_err  <= (chan_err  && !clear_err) || chan_evt;
      frame_err <= (frame_err && !clear_err) || frame_evt;
    end
  end

endmodule
